// File: rtl/delay_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : delay_resp_checker
// Description : Hardware twin of the "a |-> ##DELAY b" property. Every sampled
//               en&a launches an attempt that is judged DELAY edges later
//               against b, giving pass/fail pulses, saturating pass/fail
//               counters, a free-running edge counter and a sticky first-fail
//               timestamp.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_resp_checker #(
    parameter int DELAY = 2,   // edges from attempt start to evaluation, >= 1
    parameter int CNT_W = 16   // width of all counters and the timestamp
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic             pass,
    output logic             fail,
    output logic             err_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] first_fail_cyc,
    output logic             busy
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    // One bit per attempt still in flight; bit i set means the attempt was
    // launched i+1 edges ago. The top bit is the attempt maturing this edge.
    logic [DELAY-1:0] pipe_q, pipe_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] ffc_q, ffc_d;

    logic             w_mature;

    assign w_mature = pipe_q[DELAY-1];

    // Next-state: shift attempts, judge the maturing one, update counters;
    // a clear wins over everything including a simultaneous evaluation.
    always_comb begin
        pipe_d     = pipe_q << 1;
        pipe_d[0]  = en & a;
        pass_d     = w_mature & b;
        fail_d     = w_mature & ~b;
        err_d      = err_q;
        ffc_d      = ffc_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        cyc_cnt_d  = cyc_cnt_q + C_CNT_ONE;

        if (pass_d && (pass_cnt_q != C_CNT_MAX)) begin
            pass_cnt_d = pass_cnt_q + C_CNT_ONE;
        end

        if (fail_d) begin
            if (fail_cnt_q != C_CNT_MAX) begin
                fail_cnt_d = fail_cnt_q + C_CNT_ONE;
            end
            // Timestamp is the counter value seen at the failing edge itself.
            if (!err_q) begin
                err_d = 1'b1;
                ffc_d = cyc_cnt_q;
            end
        end

        if (clr) begin
            pipe_d     = '0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            err_d      = 1'b0;
            ffc_d      = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            cyc_cnt_d  = '0;
        end
    end

    // State registers; reset discards in-flight attempts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q     <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= 1'b0;
            ffc_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            pipe_q     <= pipe_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            ffc_q      <= ffc_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    assign pass           = pass_q;
    assign fail           = fail_q;
    assign err_sticky     = err_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign cyc_cnt        = cyc_cnt_q;
    assign first_fail_cyc = ffc_q;
    assign busy           = |pipe_q;

endmodule
`default_nettype wire
